// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - ZBT-to-VGA pixel scanout: prefetches packed words ahead of the beam,
// unpacks one pixel per clock, with 2x zoom and double-buffered frame swap.
module vram_scanout #(
   parameter int PIX_W    = 8,
   parameter int PPW      = 4,
   parameter int WORD_W   = 36,
   parameter int ADDR_W   = 19,
   parameter int H_ACTIVE = 1024,
   parameter int V_ACTIVE = 768,
   parameter int H_TOTAL  = 1344,
   parameter int V_TOTAL  = 806,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [10:0]       hcount,
   input  logic [9:0]        vcount,
   input  logic              zoom_req,
   input  logic              frame_swap,
   output logic [ADDR_W-1:0] vram_addr,
   input  logic [WORD_W-1:0] vram_read_data,
   output logic [PIX_W-1:0]  vr_pixel,
   output logic              pixel_valid,
   output logic              frame_sel,
   output logic              swap_ack
);

   localparam int COL_W   = $clog2(H_ACTIVE / PPW);
   localparam int ROW_W   = 10;
   localparam int LEAD    = READ_LAT + 2;
   localparam int LANE_W  = $clog2(PPW);
   localparam int PK_W    = PIX_W * PPW;
   localparam int AW_USED = 1 + ROW_W + COL_W;

   logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
   logic [READ_LAT:0] fetch_sr_q, fetch_sr_d;
   logic [PK_W-1:0]   stage_q, stage_d;
   logic [PK_W-1:0]   disp_q, disp_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic              valid_q, valid_d;
   logic              frame_sel_q, frame_sel_d;
   logic              swap_ack_q, swap_ack_d;
   logic              swap_pending_q, swap_pending_d;
   logic              zoom_active_q, zoom_active_d;
   logic              run_q, run_d;

   logic [11:0]        fh, sx;
   logic [10:0]        fv, sy;
   logic [10:0]        hp;
   logic [LANE_W-1:0]  lane;
   logic [AW_USED-1:0] addr_next;
   logic [PK_W-1:0]    cur_word;
   logic               fetch_act, fetch_first, beam_act, word_start, is_b;
   logic               unused_bits;

   assign unused_bits = ^{vram_read_data, sx, sy, hp};

   // Fetch side: beam position LEAD clocks ahead, wrapping into the next line/frame.
   always_comb begin
      fh = {1'b0, hcount} + 12'(LEAD);
      fv = {1'b0, vcount};
      if (fh >= 12'(H_TOTAL)) begin
         fh = fh - 12'(H_TOTAL);
         fv = (({1'b0, vcount} + 11'd1) == 11'(V_TOTAL)) ? '0 : ({1'b0, vcount} + 11'd1);
      end
      sx          = zoom_active_q ? {1'b0, fh[11:1]} : fh;
      sy          = zoom_active_q ? {1'b0, fv[10:1]} : fv;
      fetch_act   = (fh < 12'(H_ACTIVE)) && (fv < 11'(V_ACTIVE));
      fetch_first = fetch_act && (sx[LANE_W-1:0] == '0) && (!zoom_active_q || !fh[0]);
      addr_next   = {frame_sel_q, sy[ROW_W-1:0], sx[LANE_W +: COL_W]};
   end

   // Beam side: the first pixel of a word reads the staging register directly.
   always_comb begin
      hp         = zoom_active_q ? {1'b0, hcount[10:1]} : hcount;
      lane       = hp[LANE_W-1:0];
      beam_act   = (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
      word_start = (lane == '0) && (!zoom_active_q || !hcount[0]);
      cur_word   = word_start ? stage_q : disp_q;
      is_b       = (vcount == 10'(V_ACTIVE)) && (hcount == '0);
   end

   always_comb begin
      vram_addr_d    = fetch_act ? ADDR_W'(addr_next) : vram_addr_q;
      fetch_sr_d     = {fetch_sr_q[READ_LAT-1:0], fetch_first};
      stage_d        = fetch_sr_q[READ_LAT] ? vram_read_data[PK_W-1:0] : stage_q;
      disp_d         = word_start ? stage_q : disp_q;
      run_d          = run_q | (hcount == 11'(H_ACTIVE));
      valid_d        = beam_act && run_q;
      pix_d          = valid_d ? cur_word[int'(lane) * PIX_W +: PIX_W] : '0;
      swap_pending_d = swap_pending_q | frame_swap;
      frame_sel_d    = frame_sel_q;
      zoom_active_d  = zoom_active_q;
      swap_ack_d     = 1'b0;
      if (is_b) begin
         zoom_active_d = zoom_req;
         if (swap_pending_d) begin
            frame_sel_d    = ~frame_sel_q;
            swap_pending_d = 1'b0;
            swap_ack_d     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vram_addr_q    <= '0;
         fetch_sr_q     <= '0;
         stage_q        <= '0;
         disp_q         <= '0;
         pix_q          <= '0;
         valid_q        <= 1'b0;
         frame_sel_q    <= 1'b0;
         swap_ack_q     <= 1'b0;
         swap_pending_q <= 1'b0;
         zoom_active_q  <= 1'b0;
         run_q          <= 1'b0;
      end else begin
         vram_addr_q    <= vram_addr_d;
         fetch_sr_q     <= fetch_sr_d;
         stage_q        <= stage_d;
         disp_q         <= disp_d;
         pix_q          <= pix_d;
         valid_q        <= valid_d;
         frame_sel_q    <= frame_sel_d;
         swap_ack_q     <= swap_ack_d;
         swap_pending_q <= swap_pending_d;
         zoom_active_q  <= zoom_active_d;
         run_q          <= run_d;
      end
   end

   assign vram_addr   = vram_addr_q;
   assign vr_pixel    = pix_q;
   assign pixel_valid = valid_q;
   assign frame_sel   = frame_sel_q;
   assign swap_ack    = swap_ack_q;

endmodule

// File: tb/tb_vram_scanout.sv
// tb/tb_vram_scanout.sv - directed vectors for vram_scanout (defaults, READ_LAT=1, 16-bit/PPW=2 variants).
module tb_vram_scanout;

   localparam int HT = 1344;
   localparam int VT = 806;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        zoom_req, frame_swap;

   logic [18:0] addr1, addr3;
   logic [19:0] addr2;
   logic [35:0] rd1, rd3;
   logic [31:0] rd2;
   logic [7:0]  pix1, pix3;
   logic [15:0] pix2;
   logic        val1, val2, val3, fs1, fs2, fs3, ack1, ack2, ack3;

   int bv, bh;
   int n_cmp = 0;
   int n_bad = 0;
   logic chk2_en = 1'b0;

   typedef struct {
      int         v;
      int         h;
      logic       valid;
      logic [7:0] pix;
      logic [18:0] addr;
   } vec_t;

   vec_t tbl_a[$];
   vec_t tbl_z[$];

   always #5 clk = ~clk;

   assign hcount = 11'(bh);
   assign vcount = 10'(bv);

   vram_scanout u_dut (
      .clk(clk), .reset(rst), .hcount(hcount), .vcount(vcount),
      .zoom_req(zoom_req), .frame_swap(frame_swap), .vram_addr(addr1),
      .vram_read_data(rd1), .vr_pixel(pix1), .pixel_valid(val1),
      .frame_sel(fs1), .swap_ack(ack1)
   );

   vram_scanout #(.PIX_W(16), .PPW(2), .WORD_W(32), .ADDR_W(20), .READ_LAT(4)) u_dut2 (
      .clk(clk), .reset(rst), .hcount(hcount), .vcount(vcount),
      .zoom_req(zoom_req), .frame_swap(frame_swap), .vram_addr(addr2),
      .vram_read_data(rd2), .vr_pixel(pix2), .pixel_valid(val2),
      .frame_sel(fs2), .swap_ack(ack2)
   );

   vram_scanout #(.READ_LAT(1)) u_dut3 (
      .clk(clk), .reset(rst), .hcount(hcount), .vcount(vcount),
      .zoom_req(zoom_req), .frame_swap(frame_swap), .vram_addr(addr3),
      .vram_read_data(rd3), .vr_pixel(pix3), .pixel_valid(val3),
      .frame_sel(fs3), .swap_ack(ack3)
   );

   // RAM contents: byte0 = column word, byte1 = row, byte2 = 0x0A | frame bit<<7, byte3 = 0xC3.
   function automatic logic [35:0] word1(input logic [18:0] a);
      return {4'hF, 8'hC3, a[18], a[17:16], 5'h0A, a[15:8], a[7:0]};
   endfunction

   function automatic logic [31:0] word2(input logic [19:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   logic [18:0] p1a, p1b, p3;
   logic [19:0] p2 [0:3];

   always @(posedge clk) begin
      p1a   <= addr1;
      p1b   <= p1a;
      p3    <= addr3;
      p2[0] <= addr2;
      p2[1] <= p2[0];
      p2[2] <= p2[1];
      p2[3] <= p2[2];
   end

   assign rd1 = word1(p1b);
   assign rd2 = word2(p2[3]);
   assign rd3 = word1(p3);

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_chk(input int pv, input int ph);
      logic        ev;
      logic [19:0] a2;
      logic [18:0] a3;
      logic [35:0] w;
      logic [15:0] ep2;
      logic [7:0]  ep3;
      ev  = (ph < 1024) && (pv < 768);
      a2  = 20'((pv << 9) | (ph >> 1));
      a3  = 19'((pv << 8) | (ph >> 2));
      w   = word1(a3);
      ep2 = ev ? ((ph % 2 == 1) ? ~a2[15:0] : a2[15:0]) : 16'h0;
      ep3 = ev ? w[(ph % 4) * 8 +: 8] : 8'h0;
      cmp($sformatf("d2_valid(%0d,%0d)", pv, ph), 32'(val2), 32'(ev));
      cmp($sformatf("d2_pix(%0d,%0d)", pv, ph), 32'(pix2), 32'(ep2));
      cmp($sformatf("d3_valid(%0d,%0d)", pv, ph), 32'(val3), 32'(ev));
      cmp($sformatf("d3_pix(%0d,%0d)", pv, ph), 32'(pix3), 32'(ep3));
   endtask

   task automatic tick();
      int pv, ph;
      pv = bv;
      ph = bh;
      @(posedge clk);
      #1;
      if (chk2_en && pv >= 4 && pv <= 6) model_chk(pv, ph);
      bh++;
      if (bh == HT) begin
         bh = 0;
         bv++;
         if (bv == VT) bv = 0;
      end
   endtask

   task automatic goto(input int v, input int h);
      int n;
      n = 0;
      while (!(bv == v && bh == h) && n < 20000) begin
         tick();
         n++;
      end
      if (n >= 20000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL goto(%0d,%0d): beam at (%0d,%0d) after %0d steps", v, h, bv, bh, n);
      end
   endtask

   task automatic chk_at(input vec_t t, input string tag);
      goto(t.v, t.h);
      tick();
      cmp($sformatf("%s_valid(%0d,%0d)", tag, t.v, t.h), 32'(val1), 32'(t.valid));
      cmp($sformatf("%s_pix(%0d,%0d)", tag, t.v, t.h), 32'(pix1), 32'(t.pix));
      cmp($sformatf("%s_addr(%0d,%0d)", tag, t.v, t.h), 32'(addr1), 32'(t.addr));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl_a.push_back('{4,    0,    1'b1, 8'h00, 19'h00401});
      tbl_a.push_back('{5,    0,    1'b1, 8'h00, 19'h00501});
      tbl_a.push_back('{5,    1,    1'b1, 8'h05, 19'h00501});
      tbl_a.push_back('{5,    2,    1'b1, 8'h0A, 19'h00501});
      tbl_a.push_back('{5,    3,    1'b1, 8'hC3, 19'h00501});
      tbl_a.push_back('{5,    4,    1'b1, 8'h01, 19'h00502});
      tbl_a.push_back('{5,    5,    1'b1, 8'h05, 19'h00502});
      tbl_a.push_back('{5,    7,    1'b1, 8'hC3, 19'h00502});
      tbl_a.push_back('{5,    1020, 1'b1, 8'hFF, 19'h005FF});
      tbl_a.push_back('{5,    1023, 1'b1, 8'hC3, 19'h005FF});
      tbl_a.push_back('{5,    1024, 1'b0, 8'h00, 19'h005FF});
      tbl_a.push_back('{5,    1200, 1'b0, 8'h00, 19'h005FF});
      tbl_a.push_back('{5,    1343, 1'b0, 8'h00, 19'h00600});
      tbl_a.push_back('{6,    0,    1'b1, 8'h00, 19'h00601});
      tbl_a.push_back('{6,    1,    1'b1, 8'h06, 19'h00601});

      tbl_z.push_back('{0,    0,    1'b1, 8'h00, 19'h40000});
      tbl_z.push_back('{0,    2,    1'b1, 8'h00, 19'h40000});
      tbl_z.push_back('{0,    4,    1'b1, 8'h8A, 19'h40001});
      tbl_z.push_back('{0,    5,    1'b1, 8'h8A, 19'h40001});
      tbl_z.push_back('{0,    7,    1'b1, 8'hC3, 19'h40001});
      tbl_z.push_back('{0,    8,    1'b1, 8'h01, 19'h40001});
      tbl_z.push_back('{1,    2,    1'b1, 8'h00, 19'h40000});
      tbl_z.push_back('{2,    2,    1'b1, 8'h01, 19'h40100});
      tbl_z.push_back('{2,    1016, 1'b1, 8'h7F, 19'h4017F});

      rst        = 1'b1;
      zoom_req   = 1'b0;
      frame_swap = 1'b0;
      bv         = 3;
      bh         = 1000;
      repeat (3) @(posedge clk);
      #1;
      cmp("reset_addr", 32'(addr1), 32'h0);
      cmp("reset_pix", 32'(pix1), 32'h0);
      cmp("reset_valid", 32'(val1), 32'h0);
      cmp("reset_frame_sel", 32'(fs1), 32'h0);
      cmp("reset_swap_ack", 32'(ack1), 32'h0);
      rst = 1'b0;

      // Normal frame 0 scan, with the two parameter variants checked every cycle of lines 4..6.
      chk2_en = 1'b1;
      foreach (tbl_a[i]) chk_at(tbl_a[i], "a");
      goto(7, 0);
      chk2_en = 1'b0;

      // Swap requests away from B are only recorded; two pulses merge into one toggle.
      bv = 10;
      bh = 90;
      goto(10, 100);
      frame_swap = 1'b1;
      tick();
      frame_swap = 1'b0;
      cmp("swap_nonb_ack", 32'(ack1), 32'h0);
      cmp("swap_nonb_sel", 32'(fs1), 32'h0);
      goto(10, 200);
      frame_swap = 1'b1;
      tick();
      frame_swap = 1'b0;
      zoom_req = 1'b1;
      chk_at('{10, 300, 1'b1, 8'h4B, 19'h00A4C}, "midzoom");
      cmp("swap_pending_sel", 32'(fs1), 32'h0);

      bv = 767;
      bh = 1340;
      goto(768, 0);
      tick();
      cmp("swap_b_ack", 32'(ack1), 32'h1);
      cmp("swap_b_sel", 32'(fs1), 32'h1);
      tick();
      cmp("swap_b1_ack", 32'(ack1), 32'h0);
      cmp("swap_merge_sel", 32'(fs1), 32'h1);

      // Frame wrap into a zoomed frame 1.
      bv = 805;
      bh = 1000;
      foreach (tbl_z[i]) chk_at(tbl_z[i], "z");

      // Reset in the middle of a line.
      chk_at('{3, 500, 1'b1, 8'h8A, 19'h4013F}, "prerst");
      rst = 1'b1;
      #1;
      cmp("midrst_addr", 32'(addr1), 32'h0);
      cmp("midrst_pix", 32'(pix1), 32'h0);
      cmp("midrst_valid", 32'(val1), 32'h0);
      cmp("midrst_frame_sel", 32'(fs1), 32'h0);
      cmp("midrst_swap_ack", 32'(ack1), 32'h0);
      repeat (3) tick();
      rst = 1'b0;
      chk_at('{3, 700, 1'b0, 8'h00, 19'h003B0}, "postrst");
      chk_at('{4, 5, 1'b1, 8'h04, 19'h00402}, "postrst");
      chk_at('{4, 6, 1'b1, 8'h0A, 19'h00402}, "postrst");

      // A pulse coinciding exactly with B toggles immediately.
      zoom_req = 1'b0;
      bv = 767;
      bh = 1340;
      goto(768, 0);
      frame_swap = 1'b1;
      tick();
      frame_swap = 1'b0;
      cmp("swap_at_b_ack", 32'(ack1), 32'h1);
      cmp("swap_at_b_sel", 32'(fs1), 32'h1);
      tick();
      cmp("swap_at_b1_ack", 32'(ack1), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
